// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded LEGv8 instruction at a time to the
// 64-bit ALU, waits for the result and delayed Zero flag to settle, captures
// them and returns result, flags and branch decision over a valid/ready
// response channel.
module alu_issue_ctrl #(
    parameter int WIDTH         = 64,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             Clk,
    input  logic             Resetb,
    // request channel
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [10:0]      ReqOpcode,
    input  logic [WIDTH-1:0] ReqA,
    input  logic [WIDTH-1:0] ReqB,
    // ALU side
    output logic [WIDTH-1:0] AluBusA,
    output logic [WIDTH-1:0] AluBusB,
    output logic [3:0]       AluCtrl,
    input  logic [WIDTH-1:0] AluBusW,
    input  logic             AluZero,
    // response channel
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspResult,
    output logic             RspZero,
    output logic             RspTaken,
    output logic             RspIllegal
);

    // Counter only has to hold SETTLE_CYCLES; keep at least one bit.
    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_CYCLES);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_ORR = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_MOV = 4'b0111;
    localparam logic [3:0] CTRL_CB  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_CBZ  = 2'd1,
        BR_CBNZ = 2'd2
    } branch_t;

    state_t           state_q, state_d;
    branch_t          branch_q, branch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_taken_q, rsp_taken_d;
    logic             rsp_illegal_q, rsp_illegal_d;

    logic             dec_legal;
    logic [3:0]       dec_ctrl;
    branch_t          dec_branch;

    // Opcode decode: ALU control code, branch kind and legality.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the case leaves it unassigned and infers a latch.
        dec_legal  = 1'b1;
        dec_ctrl   = CTRL_AND;
        dec_branch = BR_NONE;
        casez (ReqOpcode)
            11'b10001011000: dec_ctrl = CTRL_ADD;
            11'b11001011000: dec_ctrl = CTRL_SUB;
            11'b10001010000: dec_ctrl = CTRL_AND;
            11'b10101010000: dec_ctrl = CTRL_ORR;
            11'b11111000010: dec_ctrl = CTRL_ADD;   // LDUR
            11'b11111000000: dec_ctrl = CTRL_ADD;   // STUR
            11'b110100101??: dec_ctrl = CTRL_MOV;   // MOVZ
            11'b10110100???: begin
                dec_ctrl   = CTRL_CB;
                dec_branch = BR_CBZ;
            end
            11'b10110101???: begin
                dec_ctrl   = CTRL_CB;
                dec_branch = BR_CBNZ;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state logic: accept, settle countdown, capture, response handshake.
    always_comb begin
        state_d       = state_q;
        branch_d      = branch_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_ctrl_d    = alu_ctrl_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_taken_d   = rsp_taken_q;
        rsp_illegal_d = rsp_illegal_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ReqValid) begin
                    branch_d = dec_branch;
                    if (dec_legal) begin
                        alu_a_d    = ReqA;
                        alu_b_d    = ReqB;
                        alu_ctrl_d = dec_ctrl;
                        cnt_d      = SETTLE_CNT;
                        state_d    = ST_EXEC;
                    end else begin
                        // Illegal ops never touch the ALU buses.
                        rsp_result_d  = '0;
                        rsp_zero_d    = 1'b0;
                        rsp_taken_d   = 1'b0;
                        rsp_illegal_d = 1'b1;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_result_d  = AluBusW;
                    rsp_zero_d    = AluZero;
                    rsp_illegal_d = 1'b0;
                    unique case (branch_q)
                        BR_CBZ:  rsp_taken_d = AluZero;
                        BR_CBNZ: rsp_taken_d = ~AluZero;
                        default: rsp_taken_d = 1'b0;
                    endcase
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (RspReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; every flop has a defined reset value.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values regardless of statement order.
            state_q       <= ST_IDLE;
            branch_q      <= BR_NONE;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctrl_q    <= CTRL_AND;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_taken_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            branch_q      <= branch_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_taken_q   <= rsp_taken_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign ReqReady   = (state_q == ST_IDLE);
    assign RspValid   = (state_q == ST_RESP);
    assign AluBusA    = alu_a_q;
    assign AluBusB    = alu_b_q;
    assign AluCtrl    = alu_ctrl_q;
    assign RspResult  = rsp_result_q;
    assign RspZero    = rsp_zero_q;
    assign RspTaken   = rsp_taken_q;
    assign RspIllegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives alu_issue_ctrl with directed and random requests,
// provides a stand-in ALU with a one-cycle delayed Zero flag, and compares
// every cycle against a transaction-level timeline model.
module tb_alu_issue_ctrl;

    localparam int WIDTH  = 64;
    localparam int SETTLE = 1;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    logic             Clk = 1'b0;
    logic             Resetb;
    logic             ReqValid, ReqReady;
    logic [10:0]      ReqOpcode;
    logic [WIDTH-1:0] ReqA, ReqB;
    logic [WIDTH-1:0] AluBusA, AluBusB, AluBusW;
    logic [3:0]       AluCtrl;
    logic             AluZero;
    logic             RspValid, RspReady;
    logic [WIDTH-1:0] RspResult;
    logic             RspZero, RspTaken, RspIllegal;

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    alu_issue_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
        .Clk(Clk), .Resetb(Resetb),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOpcode(ReqOpcode),
        .ReqA(ReqA), .ReqB(ReqB),
        .AluBusA(AluBusA), .AluBusB(AluBusB), .AluCtrl(AluCtrl),
        .AluBusW(AluBusW), .AluZero(AluZero),
        .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult),
        .RspZero(RspZero), .RspTaken(RspTaken), .RspIllegal(RspIllegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stand-in ALU: combinational result, registered Zero
    always_comb begin
        AluBusW = '0;
        case (AluCtrl)
            4'b0010: AluBusW = AluBusA + AluBusB;
            4'b0110: AluBusW = AluBusA - AluBusB;
            4'b0000: AluBusW = AluBusA & AluBusB;
            4'b0001: AluBusW = AluBusA | AluBusB;
            4'b0111: AluBusW = AluBusB;
            4'b1000: AluBusW = AluBusB;
            default: AluBusW = '0;
        endcase
    end

    always @(posedge Clk or negedge Resetb)
        if (!Resetb) AluZero <= 1'b0;
        else         AluZero <= (AluBusW == '0);

    // ---------------- behavioural model (instruction-level)
    typedef struct packed {
        bit          legal;
        logic [3:0]  ctrl;
        logic [63:0] res;
        bit          zero;
        bit          taken;
    } pred_t;

    function automatic pred_t predict(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b);
        pred_t p;
        p = '0;
        p.legal = 1'b1;
        if (op == OP_ADD || op == OP_LDUR || op == OP_STUR) begin p.ctrl = 4'b0010; p.res = a + b; end
        else if (op == OP_SUB)                 begin p.ctrl = 4'b0110; p.res = a - b; end
        else if (op == OP_AND)                 begin p.ctrl = 4'b0000; p.res = a & b; end
        else if (op == OP_ORR)                 begin p.ctrl = 4'b0001; p.res = a | b; end
        else if (op ==? 11'b110100101??)       begin p.ctrl = 4'b0111; p.res = b; end
        else if (op ==? 11'b1011010????)       begin p.ctrl = 4'b1000; p.res = b; end
        else p.legal = 1'b0;
        p.zero = (p.res == 64'd0);
        if (op ==? 11'b10110100???) p.taken = p.zero;
        if (op ==? 11'b10110101???) p.taken = !p.zero;
        return p;
    endfunction

    pred_t p_now;
    assign p_now = predict(ReqOpcode, ReqA, ReqB);

    // Timeline model: an accepted op owns the block until its response is
    // taken; the response appears a fixed latency after acceptance.
    int unsigned cyc;
    int unsigned m_rsp_at;
    bit          m_busy;
    logic [63:0] m_a, m_b, m_res;
    logic [3:0]  m_ctrl;
    bit          m_zero, m_taken, m_ill;
    wire         m_valid = m_busy && (cyc > m_rsp_at);

    always @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            cyc <= 0; m_busy <= 0; m_rsp_at <= 0;
            m_a <= '0; m_b <= '0; m_ctrl <= '0;
            m_res <= '0; m_zero <= 0; m_taken <= 0; m_ill <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!m_busy) begin
                if (ReqValid) begin
                    m_busy <= 1;
                    if (p_now.legal) begin
                        m_rsp_at <= cyc + SETTLE + 1;
                        m_a <= ReqA; m_b <= ReqB; m_ctrl <= p_now.ctrl;
                        m_res <= p_now.res; m_zero <= p_now.zero;
                        m_taken <= p_now.taken; m_ill <= 0;
                    end else begin
                        m_rsp_at <= cyc;
                        m_res <= '0; m_zero <= 0; m_taken <= 0; m_ill <= 1;
                    end
                end
            end else if (cyc > m_rsp_at && RspReady) begin
                m_busy <= 0;
            end
        end
    end

    // ---------------- per-cycle compare against the model
    always @(negedge Clk) begin
        check("req_ready", ReqReady, !m_busy);
        check("rsp_valid", RspValid, m_valid);
        check("alu_bus_a", AluBusA, m_a);
        check("alu_bus_b", AluBusB, m_b);
        check("alu_ctrl", AluCtrl, m_ctrl);
        check("alu_ctrl_in_list", AluCtrl inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000}, 1);
        if (m_valid) begin
            check("rsp_result", RspResult, m_res);
            check("rsp_zero", RspZero, m_zero);
            check("rsp_taken", RspTaken, m_taken);
            check("rsp_illegal", RspIllegal, m_ill);
        end
    end

    // ---------------- directed helpers
    // Called at a negedge with the block idle; returns at the negedge where
    // RspValid is first seen (RspReady held high, so it is taken next edge).
    task automatic run_op(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b,
                          output int lat, output logic [3:0] ctrl_seen);
        ReqOpcode = op; ReqA = a; ReqB = b; ReqValid = 1'b1; RspReady = 1'b1;
        lat = 0;
        ctrl_seen = 4'hF;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            ReqValid = 1'b0;
            if (i == 1) ctrl_seen = AluCtrl;
            if (RspValid) begin
                lat = i;
                break;
            end
        end
        check("rsp_timeout", (lat != 0), 1);
    endtask

    task automatic finish_op();
        @(negedge Clk);
        check("ready_after_handshake", ReqReady, 1);
        check("valid_drop_after_handshake", RspValid, 0);
    endtask

    task automatic wait_rsp(input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (RspValid) seen = 1;
            else @(negedge Clk);
        end
        check(name, seen, 1);
    endtask

    // ---------------- stimulus
    initial begin
        int          lat;
        logic [3:0]  ctl;
        logic [10:0] op;
        logic [63:0] a, b;

        Resetb = 1'b0;
        ReqValid = 0; ReqOpcode = '0; ReqA = '0; ReqB = '0; RspReady = 0;
        repeat (2) @(negedge Clk);
        check("reset_req_ready", ReqReady, 1);
        check("reset_rsp_valid", RspValid, 0);
        check("reset_alu_ctrl", AluCtrl, 0);
        check("reset_alu_a", AluBusA, 0);
        check("reset_rsp_result", RspResult, 0);
        check("reset_rsp_illegal", RspIllegal, 0);
        Resetb = 1'b1;
        @(negedge Clk);

        // ADD 5 + 7
        run_op(OP_ADD, 64'd5, 64'd7, lat, ctl);
        check("add_ctrl", ctl, 4'b0010);
        check("add_latency", lat, 3);
        check("add_result", RspResult, 64'd12);
        check("add_zero", RspZero, 0);
        check("add_taken", RspTaken, 0);
        check("add_illegal", RspIllegal, 0);
        finish_op();

        // SUB 9 - 9
        run_op(OP_SUB, 64'd9, 64'd9, lat, ctl);
        check("sub_eq_result", RspResult, 64'd0);
        check("sub_eq_zero", RspZero, 1);
        finish_op();

        // SUB 3 - 5 wraps to all-ones minus one
        run_op(OP_SUB, 64'd3, 64'd5, lat, ctl);
        check("sub_neg_result", RspResult, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_neg_zero", RspZero, 0);
        finish_op();

        // CBZ B=0, CBNZ B=0, CBZ B=4
        run_op(11'b10110100101, 64'd1, 64'd0, lat, ctl);
        check("cbz0_ctrl", ctl, 4'b1000);
        check("cbz0_taken", RspTaken, 1);
        finish_op();
        run_op(11'b10110101011, 64'd1, 64'd0, lat, ctl);
        check("cbnz0_ctrl", ctl, 4'b1000);
        check("cbnz0_taken", RspTaken, 0);
        finish_op();
        run_op(11'b10110100000, 64'd1, 64'd4, lat, ctl);
        check("cbz4_taken", RspTaken, 0);
        finish_op();

        // Illegal opcode: response right after accept, ALU untouched
        run_op(11'b00000000000, 64'd77, 64'd88, lat, ctl);
        check("ill_latency", lat, 1);
        check("ill_flag", RspIllegal, 1);
        check("ill_result", RspResult, 0);
        check("ill_ctrl_unchanged", AluCtrl, 4'b1000);
        check("ill_bus_b_unchanged", AluBusB, 64'd4);
        finish_op();

        // ORR with RspReady low for 5 cycles while a new request waits
        ReqOpcode = OP_ORR; ReqA = 64'hF0; ReqB = 64'h0F; ReqValid = 1; RspReady = 0;
        @(negedge Clk);
        ReqOpcode = OP_ADD; ReqA = 64'd1; ReqB = 64'd2; ReqValid = 1;
        wait_rsp("orr_rsp_seen");
        for (int i = 0; i < 5; i++) begin
            check("orr_hold_result", RspResult, 64'hFF);
            check("orr_hold_valid", RspValid, 1);
            check("orr_hold_not_ready", ReqReady, 0);
            if (i < 4) @(negedge Clk);
        end
        RspReady = 1;
        @(negedge Clk);
        check("orr_after_hs_ready", ReqReady, 1);
        check("orr_after_hs_ctrl", AluCtrl, 4'b0001);
        @(negedge Clk);
        ReqValid = 0;
        check("next_accepted", ReqReady, 0);
        check("next_ctrl", AluCtrl, 4'b0010);
        check("next_bus_a", AluBusA, 64'd1);
        wait_rsp("next_rsp_seen");
        check("next_result", RspResult, 64'd3);
        finish_op();

        // Reset in the middle of EXEC for an ADD
        ReqOpcode = OP_ADD; ReqA = 64'd5; ReqB = 64'd7; ReqValid = 1; RspReady = 1;
        @(negedge Clk);
        ReqValid = 0;
        check("midrst_in_exec", ReqReady, 0);
        #2 Resetb = 1'b0;
        #1;
        check("midrst_req_ready", ReqReady, 1);
        check("midrst_rsp_valid", RspValid, 0);
        check("midrst_alu_a", AluBusA, 0);
        check("midrst_alu_b", AluBusB, 0);
        check("midrst_alu_ctrl", AluCtrl, 0);
        check("midrst_rsp_result", RspResult, 0);
        check("midrst_rsp_zero", RspZero, 0);
        check("midrst_rsp_taken", RspTaken, 0);
        check("midrst_rsp_illegal", RspIllegal, 0);
        @(negedge Clk);
        Resetb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            check("midrst_no_rsp", RspValid, 0);
        end

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 9))
                0: op = OP_ADD;
                1: op = OP_SUB;
                2: op = OP_AND;
                3: op = OP_ORR;
                4: op = ($urandom_range(0, 1) != 0) ? OP_LDUR : OP_STUR;
                5: op = {9'b110100101, 2'($urandom)};
                6: op = {8'b10110100, 3'($urandom)};
                7: op = {8'b10110101, 3'($urandom)};
                default: op = 11'($urandom);
            endcase
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = 64'd0;
                1: b = a;
                default: b = {$urandom, $urandom};
            endcase
            ReqOpcode = op; ReqA = a; ReqB = b;
            ReqValid = ($urandom_range(0, 1) != 0);
            RspReady = ($urandom_range(0, 9) < 7);
            @(negedge Clk);
        end
        ReqValid = 0;
        RspReady = 1;
        repeat (4) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Execute-stage issuing controller that sits in front of the 64-bit ALU and acts as its initiator. It accepts one decoded instruction at a time over a valid/ready request channel and maps the opcode to an ALU control code. It drives registered operands and control into the ALU, waits for the ALU result and its delayed Zero flag to settle, then captures them. The captured result, flags and branch decision are returned over a valid/ready response channel.

## Interface
- WIDTH, 64, operand/result width
- SETTLE_CYCLES, 1, extra cycles to wait after driving the ALU before capture (≥1; covers the ALU Zero delay)
- Clk  in  1  clock, all state on rising edge
- Resetb  in  1  asynchronous, active-low reset
- ReqValid  in  1  request valid
- ReqReady  out  1  high exactly when state is IDLE
- ReqOpcode  in  11  LEGv8 opcode field [31:21]
- ReqA  in  WIDTH  first operand
- ReqB  in  WIDTH  second operand (register, offset or immediate, already selected upstream)
- AluBusA  out  WIDTH  registered operand A to ALU
- AluBusB  out  WIDTH  registered operand B to ALU
- AluCtrl  out  4  registered ALU control code
- AluBusW  in  WIDTH  ALU result
- AluZero  in  1  ALU zero flag
- RspValid  out  1  response valid
- RspReady  in  1  response accepted
- RspResult  out  WIDTH  captured ALU result
- RspZero  out  1  captured zero flag
- RspTaken  out  1  branch taken (CBZ/CBNZ only)
- RspIllegal  out  1  opcode not decodable

## Operation
- Decode of ReqOpcode to AluCtrl:
  - ADD 10001011000 -> 0010
  - SUB 11001011000 -> 0110
  - AND 10001010000 -> 0000
  - ORR 10101010000 -> 0001
  - LDUR 11111000010 and STUR 11111000000 -> 0010
  - MOVZ 110100101xx -> 0111
  - CBZ 10110100xxx and CBNZ 10110101xxx -> 1000
  - anything else -> illegal
- The FSM has three states:
  - IDLE: ReqReady=1. On ReqValid, latch the operands and decoded control, and latch a branch kind of none, CBZ or CBNZ.
    - If the opcode is legal, go to EXEC with the counter set to SETTLE_CYCLES.
    - If the opcode is illegal, go directly to RESP with RspResult=0, RspZero=0, RspTaken=0, RspIllegal=1. AluBusA, AluBusB and AluCtrl are left unchanged.
  - EXEC: AluBusA, AluBusB and AluCtrl are held stable.
    - While the counter is nonzero, decrement it each edge.
    - On the edge where the counter is 0, capture RspResult=AluBusW and RspZero=AluZero, go to RESP, and set RspIllegal=0.
    - RspTaken is AluZero for CBZ, ~AluZero for CBNZ, and 0 otherwise.
  - RESP: RspValid=1 and all Rsp* outputs are held stable. On RspReady, return to IDLE.
- RspResult is AluBusW verbatim, WIDTH bits, with no extension or truncation.
- Single outstanding operation. ReqValid is ignored outside IDLE.
- AluCtrl is never driven to a code outside the decode list.

## Timing
- Reset (Resetb=0, async):
  - state=IDLE, so ReqReady=1.
  - AluBusA=0, AluBusB=0, AluCtrl=0000.
  - RspValid=0, RspResult=0, RspZero=0, RspTaken=0, RspIllegal=0.
- Reset mid-operation aborts the in-flight op; no response is produced.
- Request accept at edge E0. Legal op: AluBus*/AluCtrl valid after E0, capture at edge E(SETTLE_CYCLES+1), RspValid high after that edge.
  - With the default, RspValid is high after E2.
- Illegal op: RspValid high after E0.
- Response handshake at an edge with RspValid & RspReady: RspValid falls and ReqReady rises after that edge. The next accept is possible at the following edge.
- Default throughput: one legal op per 4 cycles when RspReady is held high.
- RspReady held low keeps RESP indefinitely with outputs stable.
- RspReady high while not in RESP has no effect.

## Test plan
- Reset with Resetb=0 mid-EXEC of an ADD:
  - Required: all outputs return to reset values immediately, ReqReady=1, and no RspValid pulse after release.
- ADD, A=5, B=7, RspReady=1:
  - Required: AluCtrl=0010; RspValid after E2 with RspResult=12, RspZero=0, RspTaken=0, RspIllegal=0; ReqReady=1 after E3.
- SUB, A=9, B=9:
  - Required: RspResult=0, RspZero=1.
- SUB, A=3, B=5:
  - Required: RspResult=64'hFFFF_FFFF_FFFF_FFFE.
- CBZ with B=0, then CBNZ with B=0, then CBZ with B=4:
  - Required: AluCtrl=1000; RspTaken=1, then 0, then 0.
- Opcode 00000000000:
  - Required: RspValid after E0 with RspIllegal=1, RspResult=0; AluCtrl unchanged from the previous op.
- ORR with A=F0, B=0F, RspReady held low for 5 cycles while ReqValid=1 with a new request:
  - Required: RspResult=FF stable for all 5 cycles; new request not accepted until the cycle after the handshake.
